scr1_pipe_mdu_iter: RTL and testbench
=====================================

// Module: scr1_pipe_mdu_iter
// PURPOSE
// Parametrised RV32M/RV64M multiply/divide unit for the EXU, split out of the IALU.
// Radix-2^DIV_BPC restoring divider plus a multiplier that is either single-cycle or
// iterative shift-add (MUL_ITER). Takes one request at a time over a req/rdy handshake.
// Holds the result until the EXU acknowledges it; supports a pipeline kill at any point.
// PARAMETERS
// XLEN       32  operand/result width; 32 or 64
// DIV_BPC    1   quotient bits per cycle; 1, 2 or 4; XLEN % DIV_BPC == 0
// MUL_ITER   0   0: single-cycle multiply; 1: iterative shift-add multiply
// MUL_BPC    4   multiplier bits per cycle when MUL_ITER=1; 1, 2, 4 or 8; divides XLEN
// PORTS
// clk                 in   1     core clock
// rst                 in   1     reset: asynchronous, active-high
// exu2mdu_req_i       in   1     request valid
// exu2mdu_cmd_i       in   3     RV M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
// exu2mdu_op1_i       in   XLEN  rs1 operand, captured at accept
// exu2mdu_op2_i       in   XLEN  rs2 operand, captured at accept
// exu2mdu_kill_i      in   1     abort current operation (flush/trap)
// exu2mdu_res_ack_i   in   1     EXU consumed result
// mdu2exu_req_rdy_o   out  1     ready to accept a request
// mdu2exu_res_vd_o    out  1     result valid
// mdu2exu_res_o       out  XLEN  result
// mdu2exu_busy_o      out  1     state != IDLE
// BEHAVIOUR
// - One clock, clk. Reset is asynchronous and active-high (rst).
// - Reset: state=IDLE, req_rdy_o=1, res_vd_o=0, res_o=0, busy_o=0.
// - Accept when req_i & req_rdy_o & ~kill_i. Operands and cmd are registered; inputs are don't-care afterwards.
// - req_rdy_o = (state==IDLE). No new accept in the cycle ack retires DONE.
// - FSM states: IDLE, CALC, CORR, DONE.
//   IDLE->DONE: fast path, i.e. single-cycle MUL, div-by-zero, or signed overflow.
//   IDLE->CALC: otherwise.
//   CALC->CORR: after N iterations.
//   CORR->DONE: always.
//   DONE->IDLE: on res_ack_i.
// - Iteration count N: N=XLEN/DIV_BPC for divide; N=XLEN/MUL_BPC for iterative multiply.
//   Iteration counter is loaded at accept and decremented each CALC cycle.
// - Latency (accept at cycle 0):
//   fast path: res_vd_o=1 in cycle 1.
//   iterative: res_vd_o=1 in cycle N+2 (XLEN=32, DIV_BPC=1: cycle 34).
// - res_o and res_vd_o are registered and held stable through DONE until ack.
//   res_vd_o deasserts the cycle after ack.
// - Divide: operands are converted to magnitudes at accept (signed cmds only).
//   Each CALC cycle retires DIV_BPC quotient bits via a chain of DIV_BPC trial subtractions on an (XLEN+1)-bit partial remainder.
//   CORR negates the quotient if the signs differ (DIV), or negates the remainder if op1 < 0 (REM).
// - Div-by-zero: quotient = all ones; remainder = op1.
// - Overflow (DIV/REM, op1=MIN_INT, op2=-1): quotient = op1; remainder = 0. No exception is raised.
// - Multiply: operand sign-extension per cmd (MULHSU: op1 signed, op2 unsigned) to XLEN+1 bits.
//   Full 2*XLEN product. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
// - Iterative multiply: operate on magnitudes, MUL_BPC partial products per cycle; CORR negates the 2*XLEN product if the result sign is negative.
// - Kill: from any state, next state is IDLE and res_vd_o=0 next cycle; partial results are discarded.
//   Kill beats a same-cycle req_i (not accepted) and a same-cycle ack.
// - rst asserted mid-operation: immediate return to reset values; no result is produced.
// - Datapath registers without reset (remainder, quotient, multiplicand, counter) are allowed.
//   Control (state, res_vd_o) must reset.
// - Area: with MUL_ITER=1, only one XLEN+1 adder chain per bit-step, shared between mul and div.
// TESTING
// XLEN=32, DIV_BPC=1, MUL_ITER=0 unless noted.
// - DIV op1=-7 (0xFFFFFFF9), op2=2 -> res_o=0xFFFFFFFD, res_vd_o first high at cycle 34. REM same operands -> 0xFFFFFFFF.
// - DIVU op1=5, op2=0 -> 0xFFFFFFFF at cycle 1. REMU 5,0 -> 5 at cycle 1.
// - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM -> 0.
// - MUL/MULH/MULHSU/MULHU with op1=op2=0xFFFFFFFF -> 0x00000001 / 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
//   Repeat with MUL_ITER=1, MUL_BPC=4: same values, latency 10.
// - Kill in cycle 10 of DIV -> res_vd_o never rises, req_rdy_o=1 in cycle 11, and the next DIV 100/7 returns 14.
//   rst pulse mid-DIV behaves likewise.
// - DIV_BPC=4, XLEN=64: DIV 0x7FFFFFFFFFFFFFFF/3 -> 0x2AAAAAAAAAAAAAAA at cycle 18.
//   Hold ack low 5 cycles -> res_o stable; req_i ignored until IDLE.

Source files
------------

// File: rtl/scr1_pipe_mdu_iter_if.sv
// EXU <-> MDU request/result channel.
// The EXU drives the master side and the multiply/divide unit sits on the slave side.
interface scr1_pipe_mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            exu2mdu_req_i;
  logic [2:0]      exu2mdu_cmd_i;
  logic [XLEN-1:0] exu2mdu_op1_i;
  logic [XLEN-1:0] exu2mdu_op2_i;
  logic            exu2mdu_kill_i;
  logic            exu2mdu_res_ack_i;
  logic            mdu2exu_req_rdy_o;
  logic            mdu2exu_res_vd_o;
  logic [XLEN-1:0] mdu2exu_res_o;
  logic            mdu2exu_busy_o;

  modport slave (
    input  exu2mdu_req_i, exu2mdu_cmd_i, exu2mdu_op1_i, exu2mdu_op2_i,
           exu2mdu_kill_i, exu2mdu_res_ack_i,
    output mdu2exu_req_rdy_o, mdu2exu_res_vd_o, mdu2exu_res_o, mdu2exu_busy_o
  );

  modport master (
    output exu2mdu_req_i, exu2mdu_cmd_i, exu2mdu_op1_i, exu2mdu_op2_i,
           exu2mdu_kill_i, exu2mdu_res_ack_i,
    input  mdu2exu_req_rdy_o, mdu2exu_res_vd_o, mdu2exu_res_o, mdu2exu_busy_o
  );
endinterface

// File: rtl/scr1_pipe_mdu_iter.sv
// RV32M/RV64M multiply/divide unit: restoring radix-2^DIV_BPC divider and a
// single-cycle or iterative shift-add multiplier that share one adder chain.
module scr1_pipe_mdu_iter #(
  parameter int XLEN     = 32,
  parameter int DIV_BPC  = 1,
  parameter int MUL_ITER = 0,
  parameter int MUL_BPC  = 4
) (
  input  logic                clk,
  input  logic                rst,
  scr1_pipe_mdu_iter_if.slave mdu
);

  localparam int CW    = $clog2(XLEN + 1);
  localparam int STEPS = ((MUL_ITER != 0) && (MUL_BPC > DIV_BPC)) ? MUL_BPC : DIV_BPC;
  localparam logic [CW-1:0]   CNT_DIV  = CW'(XLEN / DIV_BPC);
  localparam logic [CW-1:0]   CNT_MUL  = CW'(XLEN / MUL_BPC);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_CORR = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] f_neg_x(input logic [XLEN-1:0] x);
    f_neg_x = ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg_p(input logic [2*XLEN-1:0] x);
    f_neg_p = ~x + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_e          r_state;
  logic            r_res_vd;
  logic [XLEN-1:0] r_res;
  logic [2:0]      r_cmd;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opb;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;

  logic [2:0]        w_cmd;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic              w_is_div;
  logic              w_div_sgn;
  logic              w_s1;
  logic              w_s2;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic              w_accept;
  logic [2*XLEN+1:0] w_prod;
  logic              w_prod_unused;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN-1:0]   w_step_hi;
  logic [XLEN-1:0]   w_step_lo;
  logic [2*XLEN-1:0] w_prod_mag;
  logic [2*XLEN-1:0] w_prod_sgn;
  logic [XLEN-1:0]   w_corr_res;

  assign w_cmd     = mdu.exu2mdu_cmd_i;
  assign w_op1     = mdu.exu2mdu_op1_i;
  assign w_op2     = mdu.exu2mdu_op2_i;
  assign w_is_div  = w_cmd[2];
  assign w_div_sgn = w_cmd[2] & ~w_cmd[0];
  // MULHSU treats only op1 as signed; MULHU neither.
  assign w_s1      = w_is_div ? w_div_sgn : (w_cmd[1:0] != 2'b11);
  assign w_s2      = w_is_div ? w_div_sgn : ~w_cmd[1];
  assign w_neg1    = w_s1 & w_op1[XLEN-1];
  assign w_neg2    = w_s2 & w_op2[XLEN-1];
  assign w_mag1    = w_neg1 ? f_neg_x(w_op1) : w_op1;
  assign w_mag2    = w_neg2 ? f_neg_x(w_op2) : w_op2;
  assign w_div0    = w_is_div & (w_op2 == ZERO);
  assign w_ovf     = w_div_sgn & (w_op1 == MIN_INT) & (w_op2 == ALL_ONES);
  assign w_fast    = w_is_div ? (w_div0 | w_ovf) : (MUL_ITER == 0);
  assign w_accept  = (r_state == ST_IDLE) & mdu.exu2mdu_req_i & ~mdu.exu2mdu_kill_i;

  generate
    if (MUL_ITER == 0) begin : g_mul_fast
      logic [2*XLEN+1:0] w_pa;
      logic [2*XLEN+1:0] w_pb;
      assign w_pa   = {{(XLEN+2){w_neg1}}, w_op1};
      assign w_pb   = {{(XLEN+2){w_neg2}}, w_op2};
      assign w_prod = w_pa * w_pb;
    end else begin : g_mul_iter
      assign w_prod = {(2*XLEN+2){1'b0}};
    end
  endgenerate

  assign w_prod_unused = ^w_prod[2*XLEN+1:2*XLEN];

  // Result of the operations that complete in the accept cycle.
  always_comb begin
    w_fast_res = w_prod[XLEN-1:0];
    if (w_is_div) begin
      if (w_div0) begin
        w_fast_res = w_cmd[1] ? w_op1 : ALL_ONES;
      end else begin
        w_fast_res = w_cmd[1] ? ZERO : w_op1;
      end
    end else begin
      if (w_cmd[1:0] == 2'b00) begin
        w_fast_res = w_prod[XLEN-1:0];
      end else begin
        w_fast_res = w_prod[2*XLEN-1:XLEN];
      end
    end
  end

  // One CALC cycle: chained bit-steps through a single shared XLEN+1 adder each.
  always_comb begin
    logic [XLEN:0]   v_x;
    logic [XLEN:0]   v_y;
    logic [XLEN:0]   v_sum;
    logic [XLEN-1:0] v_hi;
    logic [XLEN-1:0] v_lo;
    v_x   = {(XLEN+1){1'b0}};
    v_y   = {(XLEN+1){1'b0}};
    v_sum = {(XLEN+1){1'b0}};
    v_hi  = r_hi;
    v_lo  = r_lo;
    for (int k = 0; k < STEPS; k++) begin
      if (r_cmd[2] ? (k < DIV_BPC) : (k < MUL_BPC)) begin
        if (r_cmd[2]) begin
          v_x = {v_hi, v_lo[XLEN-1]};
          v_y = ~{1'b0, r_opb};
        end else begin
          v_x = {1'b0, v_hi};
          v_y = v_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}};
        end
        v_sum = v_x + v_y + {{XLEN{1'b0}}, r_cmd[2]};
        // A restored remainder is below the divisor, so it always fits XLEN bits.
        if (r_cmd[2]) begin
          v_hi = v_sum[XLEN] ? v_x[XLEN-1:0] : v_sum[XLEN-1:0];
          v_lo = {v_lo[XLEN-2:0], ~v_sum[XLEN]};
        end else begin
          v_lo = {v_sum[0], v_lo[XLEN-1:1]};
          v_hi = v_sum[XLEN:1];
        end
      end else begin
        v_hi = v_hi;
        v_lo = v_lo;
      end
    end
    w_step_hi = v_hi;
    w_step_lo = v_lo;
  end

  assign w_prod_mag = {r_hi, r_lo};
  assign w_prod_sgn = r_neg_q ? f_neg_p(w_prod_mag) : w_prod_mag;

  // Sign correction of the magnitude result.
  always_comb begin
    w_corr_res = r_lo;
    if (r_cmd[2]) begin
      if (r_cmd[1]) begin
        w_corr_res = r_neg_r ? f_neg_x(r_hi) : r_hi;
      end else begin
        w_corr_res = r_neg_q ? f_neg_x(r_lo) : r_lo;
      end
    end else begin
      if (r_cmd[1:0] == 2'b00) begin
        w_corr_res = w_prod_sgn[XLEN-1:0];
      end else begin
        w_corr_res = w_prod_sgn[2*XLEN-1:XLEN];
      end
    end
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cmd   <= w_cmd;
      r_hi    <= ZERO;
      r_lo    <= w_is_div ? w_mag1 : w_mag2;
      r_opb   <= w_is_div ? w_mag2 : w_mag1;
      r_cnt   <= w_is_div ? CNT_DIV : CNT_MUL;
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end else if (r_state == ST_CALC) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Control FSM with registered result; kill overrides request and ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_res_vd <= 1'b0;
      r_res    <= ZERO;
    end else if (mdu.exu2mdu_kill_i) begin
      r_state  <= ST_IDLE;
      r_res_vd <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mdu.exu2mdu_req_i) begin
            if (w_fast) begin
              r_res    <= w_fast_res;
              r_res_vd <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_CORR;
          end
        end
        ST_CORR: begin
          r_res    <= w_corr_res;
          r_res_vd <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (mdu.exu2mdu_res_ack_i) begin
            r_state  <= ST_IDLE;
            r_res_vd <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_res_vd <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.mdu2exu_req_rdy_o = (r_state == ST_IDLE);
  assign mdu.mdu2exu_busy_o    = (r_state != ST_IDLE);
  assign mdu.mdu2exu_res_vd_o  = r_res_vd;
  assign mdu.mdu2exu_res_o     = r_res;

endmodule

// File: tb/tb_scr1_pipe_mdu_iter.sv
// Directed bench for three MDU builds: 32-bit single-cycle multiply,
// 32-bit iterative multiply (MUL_BPC=4) and 64-bit radix-16 divide.
module tb_scr1_pipe_mdu_iter;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic        req_m;
  logic        req_w;
  logic [2:0]  cmd;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        kill;
  logic        ack;
  int          total;
  int          bad;

  typedef struct {
    int          sel;
    logic [2:0]  cmd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  scr1_pipe_mdu_iter_if #(.XLEN(32)) if_a ();
  scr1_pipe_mdu_iter_if #(.XLEN(32)) if_m ();
  scr1_pipe_mdu_iter_if #(.XLEN(64)) if_w ();

  assign if_a.exu2mdu_req_i     = req_a;
  assign if_a.exu2mdu_cmd_i     = cmd;
  assign if_a.exu2mdu_op1_i     = op1[31:0];
  assign if_a.exu2mdu_op2_i     = op2[31:0];
  assign if_a.exu2mdu_kill_i    = kill;
  assign if_a.exu2mdu_res_ack_i = ack;
  assign if_m.exu2mdu_req_i     = req_m;
  assign if_m.exu2mdu_cmd_i     = cmd;
  assign if_m.exu2mdu_op1_i     = op1[31:0];
  assign if_m.exu2mdu_op2_i     = op2[31:0];
  assign if_m.exu2mdu_kill_i    = kill;
  assign if_m.exu2mdu_res_ack_i = ack;
  assign if_w.exu2mdu_req_i     = req_w;
  assign if_w.exu2mdu_cmd_i     = cmd;
  assign if_w.exu2mdu_op1_i     = op1;
  assign if_w.exu2mdu_op2_i     = op2;
  assign if_w.exu2mdu_kill_i    = kill;
  assign if_w.exu2mdu_res_ack_i = ack;

  scr1_pipe_mdu_iter #(.XLEN(32), .DIV_BPC(1), .MUL_ITER(0), .MUL_BPC(4)) u_a (
    .clk (clk), .rst (rst), .mdu (if_a));
  scr1_pipe_mdu_iter #(.XLEN(32), .DIV_BPC(1), .MUL_ITER(1), .MUL_BPC(4)) u_m (
    .clk (clk), .rst (rst), .mdu (if_m));
  scr1_pipe_mdu_iter #(.XLEN(64), .DIV_BPC(4), .MUL_ITER(0), .MUL_BPC(4)) u_w (
    .clk (clk), .rst (rst), .mdu (if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f_vd(input int s);
    case (s)
      0:       return if_a.mdu2exu_res_vd_o;
      1:       return if_m.mdu2exu_res_vd_o;
      default: return if_w.mdu2exu_res_vd_o;
    endcase
  endfunction

  function automatic logic f_rdy(input int s);
    case (s)
      0:       return if_a.mdu2exu_req_rdy_o;
      1:       return if_m.mdu2exu_req_rdy_o;
      default: return if_w.mdu2exu_req_rdy_o;
    endcase
  endfunction

  function automatic logic f_busy(input int s);
    case (s)
      0:       return if_a.mdu2exu_busy_o;
      1:       return if_m.mdu2exu_busy_o;
      default: return if_w.mdu2exu_busy_o;
    endcase
  endfunction

  function automatic logic [63:0] f_res(input int s);
    case (s)
      0:       return {32'h0, if_a.mdu2exu_res_o};
      1:       return {32'h0, if_m.mdu2exu_res_o};
      default: return if_w.mdu2exu_res_o;
    endcase
  endfunction

  function automatic vec_t mk(input int s, input logic [2:0] c, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] e, input int l);
    vec_t v;
    v.sel = s; v.cmd = c; v.a = a; v.b = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v);
    req_a = (s == 0) ? v : 1'b0;
    req_m = (s == 1) ? v : 1'b0;
    req_w = (s == 2) ? v : 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for the result, check latency/value, then ack.
  task automatic run(input int s, input logic [2:0] c, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] e, input int lat,
                     input string nm);
    int cyc;
    cmd = c; op1 = a; op2 = b;
    chk($sformatf("%s_rdy", nm), {63'h0, f_rdy(s)}, 64'd1);
    set_req(s, 1'b1);
    tick();
    set_req(s, 1'b0);
    cyc = 1;
    while (!f_vd(s) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk($sformatf("%s_vd", nm), {63'h0, f_vd(s)}, 64'd1);
    chk($sformatf("%s_lat", nm), 64'(cyc), 64'(lat));
    chk($sformatf("%s_res", nm), f_res(s), e);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk($sformatf("%s_vd_off", nm), {63'h0, f_vd(s)}, 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [63:0] held;
    total = 0; bad = 0;
    rst = 1'b1; req_a = 1'b0; req_m = 1'b0; req_w = 1'b0;
    cmd = 3'd0; op1 = 64'd0; op2 = 64'd0; kill = 1'b0; ack = 1'b0;

    // sel 0: 32-bit single-cycle mul
    vt.push_back(mk(0, 3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34));
    vt.push_back(mk(0, 3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 34));
    vt.push_back(mk(0, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFF, 1));
    vt.push_back(mk(0, 3'd7, 64'd5, 64'd0, 64'd5, 1));
    vt.push_back(mk(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1));
    vt.push_back(mk(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'd0, 1));
    vt.push_back(mk(0, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 1));
    vt.push_back(mk(0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 1));
    vt.push_back(mk(0, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 1));
    vt.push_back(mk(0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 1));
    vt.push_back(mk(0, 3'd5, 64'd100, 64'd7, 64'd14, 34));
    vt.push_back(mk(0, 3'd7, 64'd100, 64'd7, 64'd2, 34));
    vt.push_back(mk(0, 3'd4, 64'd7, 64'hFFFFFFFE, 64'hFFFFFFFD, 34));
    vt.push_back(mk(0, 3'd6, 64'd7, 64'hFFFFFFFE, 64'd1, 34));
    vt.push_back(mk(0, 3'd4, 64'hFFFFFFF9, 64'd0, 64'hFFFFFFFF, 1));
    vt.push_back(mk(0, 3'd6, 64'hFFFFFFF9, 64'd0, 64'hFFFFFFF9, 1));
    vt.push_back(mk(0, 3'd6, 64'h80000000, 64'd3, 64'hFFFFFFFE, 34));
    vt.push_back(mk(0, 3'd4, 64'h80000000, 64'd1, 64'h80000000, 34));
    vt.push_back(mk(0, 3'd0, 64'd3, 64'hFFFFFFFB, 64'hFFFFFFF1, 1));
    vt.push_back(mk(0, 3'd1, 64'd3, 64'hFFFFFFFB, 64'hFFFFFFFF, 1));
    vt.push_back(mk(0, 3'd3, 64'h12345678, 64'h10, 64'd1, 1));
    vt.push_back(mk(0, 3'd1, 64'h80000000, 64'h80000000, 64'h40000000, 1));
    vt.push_back(mk(0, 3'd5, 64'hFFFFFFFF, 64'd1, 64'hFFFFFFFF, 34));
    // sel 1: 32-bit iterative mul, MUL_BPC=4
    vt.push_back(mk(1, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 10));
    vt.push_back(mk(1, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 10));
    vt.push_back(mk(1, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 10));
    vt.push_back(mk(1, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 10));
    vt.push_back(mk(1, 3'd0, 64'd3, 64'hFFFFFFFB, 64'hFFFFFFF1, 10));
    vt.push_back(mk(1, 3'd1, 64'd3, 64'hFFFFFFFB, 64'hFFFFFFFF, 10));
    vt.push_back(mk(1, 3'd2, 64'hFFFFFFFF, 64'd2, 64'hFFFFFFFF, 10));
    vt.push_back(mk(1, 3'd3, 64'h80000000, 64'd4, 64'd2, 10));
    vt.push_back(mk(1, 3'd0, 64'h12345678, 64'h10, 64'h23456780, 10));
    vt.push_back(mk(1, 3'd1, 64'h80000000, 64'h80000000, 64'h40000000, 10));
    vt.push_back(mk(1, 3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34));
    vt.push_back(mk(1, 3'd7, 64'd100, 64'd7, 64'd2, 34));
    vt.push_back(mk(1, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFF, 1));
    // sel 2: 64-bit, DIV_BPC=4
    vt.push_back(mk(2, 3'd6, 64'h7FFFFFFFFFFFFFFF, 64'd3, 64'd1, 18));
    vt.push_back(mk(2, 3'd4, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 18));
    vt.push_back(mk(2, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1));
    vt.push_back(mk(2, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1));
    vt.push_back(mk(2, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1));

    repeat (2) tick();
    chk("rst_rdy", {63'h0, f_rdy(0)}, 64'd1);
    chk("rst_vd", {63'h0, f_vd(0)}, 64'd0);
    chk("rst_res", f_res(0), 64'd0);
    chk("rst_busy", {63'h0, f_busy(0)}, 64'd0);
    chk("rst_vd_w", {63'h0, f_vd(2)}, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      run(vt[i].sel, vt[i].cmd, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));
    end

    // Kill in cycle 10 of a DIV.
    cmd = 3'd4; op1 = 64'd100; op2 = 64'd7;
    set_req(0, 1'b1);
    tick();
    set_req(0, 1'b0);
    chk("kill_busy_pre", {63'h0, f_busy(0)}, 64'd1);
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_rdy", {63'h0, f_rdy(0)}, 64'd1);
    chk("kill_vd", {63'h0, f_vd(0)}, 64'd0);
    chk("kill_busy", {63'h0, f_busy(0)}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= f_vd(0);
    end
    chk("kill_no_vd", {63'h0, seen}, 64'd0);
    run(0, 3'd4, 64'd100, 64'd7, 64'd14, 34, "kill_next");

    // Kill beats a same-cycle request of a fast-path op.
    cmd = 3'd5; op1 = 64'd5; op2 = 64'd0;
    set_req(0, 1'b1);
    kill = 1'b1;
    tick();
    set_req(0, 1'b0);
    kill = 1'b0;
    chk("killreq_vd", {63'h0, f_vd(0)}, 64'd0);
    chk("killreq_busy", {63'h0, f_busy(0)}, 64'd0);

    // Kill while holding a result in DONE.
    set_req(0, 1'b1);
    tick();
    set_req(0, 1'b0);
    chk("killdone_vd_pre", {63'h0, f_vd(0)}, 64'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("killdone_vd", {63'h0, f_vd(0)}, 64'd0);
    chk("killdone_rdy", {63'h0, f_rdy(0)}, 64'd1);

    // Reset pulse mid-DIV; res_o currently holds 0xFFFFFFFF.
    cmd = 3'd4; op1 = 64'd100; op2 = 64'd7;
    set_req(0, 1'b1);
    tick();
    set_req(0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    #2;
    chk("rstmid_busy", {63'h0, f_busy(0)}, 64'd0);
    chk("rstmid_vd", {63'h0, f_vd(0)}, 64'd0);
    chk("rstmid_res", f_res(0), 64'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= f_vd(0);
    end
    chk("rstmid_no_vd", {63'h0, seen}, 64'd0);
    run(0, 3'd4, 64'd100, 64'd7, 64'd14, 34, "rstmid_next");

    // 64-bit radix-16 divide with the ack held off for 5 cycles.
    begin
      int cyc;
      cmd = 3'd4; op1 = 64'h7FFFFFFFFFFFFFFF; op2 = 64'd3;
      set_req(2, 1'b1);
      tick();
      set_req(2, 1'b0);
      cyc = 1;
      while (!f_vd(2) && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("w_div_vd", {63'h0, f_vd(2)}, 64'd1);
      chk("w_div_lat", 64'(cyc), 64'd18);
      chk("w_div_res", f_res(2), 64'h2AAAAAAAAAAAAAAA);
      held = 64'h2AAAAAAAAAAAAAAA;
      cmd = 3'd5; op1 = 64'd1; op2 = 64'd1;
      set_req(2, 1'b1);
      for (int h = 0; h < 5; h++) begin
        tick();
        chk($sformatf("hold%0d_vd", h), {63'h0, f_vd(2)}, 64'd1);
        chk($sformatf("hold%0d_res", h), f_res(2), held);
        chk($sformatf("hold%0d_rdy", h), {63'h0, f_rdy(2)}, 64'd0);
      end
      set_req(2, 1'b0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("hold_vd_off", {63'h0, f_vd(2)}, 64'd0);
      chk("hold_busy_off", {63'h0, f_busy(2)}, 64'd0);
      chk("hold_rdy_on", {63'h0, f_rdy(2)}, 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
